// File: rtl/ddr_buf_ctrl.sv
// ddr_buf_ctrl: ping-pong frame-buffer write controller feeding the adaptor's DDR write port.
// Revision 1.0
`default_nettype none

module ddr_buf_ctrl #(
  parameter int PKTS_PER_FRAME = 16,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             enable,
  input  logic             pkt_in_md_en,
  output logic             ddr_write_start,
  output logic             ddr_write_start_valid,
  input  logic             ddr_write_start_ready,
  output logic             odd_even_flag,
  input  logic             ddr_write_finish,
  input  logic             ddr_write_finish_valid,
  output logic             ddr_write_finish_ready,
  output logic             frame_done,
  output logic             frame_buf_id,
  input  logic             frame_ack,
  input  logic             frame_ack_id,
  output logic [CNT_W-1:0] pend_cnt,
  output logic [15:0]      err_cnt,
  output logic             timeout_err,
  output logic             pend_ovf
);

  localparam int PKT_W = $clog2(PKTS_PER_FRAME + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START    = 2'd1,
    WAIT_FIN = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               go;
  logic [PKT_W-1:0]   pkt_cnt;
  logic [TMR_W-1:0]   timer;
  logic [1:0]         buf_full;
  logic [1:0]         buf_full_nxt;
  logic               start_hs;
  logic               fin_hs;
  logic               timed_out;
  logic               frame_end;
  logic               write_err;

  always_comb begin
    state_nxt              = state;
    ddr_write_start_valid  = 1'b0;
    ddr_write_start        = 1'b0;
    ddr_write_finish_ready = 1'b0;
    start_hs               = 1'b0;
    fin_hs                 = 1'b0;
    timed_out              = 1'b0;
    case (state)
      IDLE: begin
        if (go) state_nxt = START;
      end
      START: begin
        ddr_write_start_valid = 1'b1;
        ddr_write_start       = 1'b1;
        start_hs              = ddr_write_start_ready;
        if (start_hs) state_nxt = WAIT_FIN;
      end
      WAIT_FIN: begin
        ddr_write_finish_ready = 1'b1;
        fin_hs    = ddr_write_finish_valid;
        timed_out = !ddr_write_finish_valid && (timer == TMR_W'(TIMEOUT_CYCLES - 1));
        if (fin_hs || timed_out) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    frame_end = fin_hs && ddr_write_finish && (pkt_cnt == PKT_W'(PKTS_PER_FRAME - 1));
    write_err = (fin_hs && !ddr_write_finish) || timed_out;

    // A release and a completion hitting the same half resolve with the set winning.
    buf_full_nxt = buf_full;
    if (frame_ack) buf_full_nxt[frame_ack_id] = 1'b0;
    if (frame_end) buf_full_nxt[odd_even_flag] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state         <= IDLE;
      go            <= 1'b0;
      pend_cnt      <= '0;
      pkt_cnt       <= '0;
      timer         <= '0;
      buf_full      <= '0;
      odd_even_flag <= 1'b0;
      frame_done    <= 1'b0;
      frame_buf_id  <= 1'b0;
      err_cnt       <= '0;
      timeout_err   <= 1'b0;
      pend_ovf      <= 1'b0;
    end else begin
      state    <= state_nxt;
      buf_full <= buf_full_nxt;
      // Start decision is taken one cycle after IDLE sees registered conditions.
      go       <= (state == IDLE) && enable && (pend_cnt != '0) && !buf_full[odd_even_flag];
      timer    <= (state == WAIT_FIN) ? timer + TMR_W'(1) : '0;

      case ({pkt_in_md_en, start_hs})
        2'b10: begin
          if (&pend_cnt) pend_ovf <= 1'b1;
          else           pend_cnt <= pend_cnt + CNT_W'(1);
        end
        2'b01:   pend_cnt <= pend_cnt - CNT_W'(1);
        default: pend_cnt <= pend_cnt;
      endcase

      frame_done <= frame_end;
      if (frame_end) begin
        frame_buf_id  <= odd_even_flag;
        odd_even_flag <= ~odd_even_flag;
        pkt_cnt       <= '0;
      end else if (fin_hs && ddr_write_finish) begin
        pkt_cnt <= pkt_cnt + PKT_W'(1);
      end

      if (write_err && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
      if (timed_out) timeout_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ddr_buf_ctrl.sv
// tb_ddr_buf_ctrl: directed stimulus with an event-level scoreboard model of ddr_buf_ctrl.
`default_nettype none

module tb_ddr_buf_ctrl;

  localparam int P  = 16;
  localparam int T  = 4096;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          enable = 1'b1;
  logic          pkt_in_md_en = 1'b0;
  logic          ddr_write_start;
  logic          ddr_write_start_valid;
  logic          ddr_write_start_ready = 1'b1;
  logic          odd_even_flag;
  logic          ddr_write_finish = 1'b0;
  logic          ddr_write_finish_valid = 1'b0;
  logic          ddr_write_finish_ready;
  logic          frame_done;
  logic          frame_buf_id;
  logic          frame_ack = 1'b0;
  logic          frame_ack_id = 1'b0;
  logic [CW-1:0] pend_cnt;
  logic [15:0]   err_cnt;
  logic          timeout_err;
  logic          pend_ovf;

  int checks = 0;
  int failures = 0;

  ddr_buf_ctrl #(.PKTS_PER_FRAME(P), .CNT_W(CW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .areset(areset), .enable(enable), .pkt_in_md_en(pkt_in_md_en),
    .ddr_write_start(ddr_write_start), .ddr_write_start_valid(ddr_write_start_valid),
    .ddr_write_start_ready(ddr_write_start_ready), .odd_even_flag(odd_even_flag),
    .ddr_write_finish(ddr_write_finish), .ddr_write_finish_valid(ddr_write_finish_valid),
    .ddr_write_finish_ready(ddr_write_finish_ready), .frame_done(frame_done),
    .frame_buf_id(frame_buf_id), .frame_ack(frame_ack), .frame_ack_id(frame_ack_id),
    .pend_cnt(pend_cnt), .err_cnt(err_cnt), .timeout_err(timeout_err), .pend_ovf(pend_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: counters and buffer ownership derived from bus-level events.
  int m_pend, m_pkts, m_err, m_wcnt, m_id, fd_count;
  bit m_flag, m_fd, m_tout, m_ovf, m_wait;
  bit m_full [2];
  bit prev_v, prev_r, prev_f;

  always @(negedge clk) begin
    bit sh, fh;
    if (areset) begin
      m_pend = 0; m_pkts = 0; m_err = 0; m_wcnt = 0; m_id = 0; fd_count = 0;
      m_flag = 0; m_fd = 0; m_tout = 0; m_ovf = 0; m_wait = 0;
      m_full[0] = 0; m_full[1] = 0;
      prev_v = 0; prev_r = 0; prev_f = 0;
    end else begin
      check("pend_cnt", pend_cnt, m_pend);
      check("err_cnt", err_cnt, m_err);
      check("odd_even_flag", odd_even_flag, m_flag);
      check("frame_done", frame_done, m_fd);
      if (m_fd) check("frame_buf_id", frame_buf_id, m_id);
      check("timeout_err", timeout_err, m_tout);
      check("pend_ovf", pend_ovf, m_ovf);
      check("finish_ready", ddr_write_finish_ready, m_wait);
      if (ddr_write_start_valid) check("start_level", ddr_write_start, 1);
      if (prev_v && !prev_r) begin
        check("start_hold_valid", ddr_write_start_valid, 1);
        check("start_hold_flag", odd_even_flag, prev_f);
      end
      if (ddr_write_start_valid && !prev_v)
        check("start_allowed", (m_pend != 0) && !m_full[m_flag], 1);
      if (frame_done) fd_count++;

      sh = ddr_write_start_valid && ddr_write_start_ready;
      fh = m_wait && ddr_write_finish_valid;
      m_fd = 0;
      if (pkt_in_md_en && !sh) begin
        if (m_pend == 255) m_ovf = 1; else m_pend++;
      end else if (sh && !pkt_in_md_en) begin
        m_pend--;
      end
      if (frame_ack) m_full[frame_ack_id] = 0;
      if (m_wait) begin
        if (fh) begin
          m_wait = 0;
          if (ddr_write_finish) begin
            m_pkts++;
            if (m_pkts == P) begin
              m_fd = 1; m_id = m_flag; m_full[m_flag] = 1; m_flag = !m_flag; m_pkts = 0;
            end
          end else if (m_err < 65535) m_err++;
        end else begin
          m_wcnt++;
          if (m_wcnt == T) begin
            m_tout = 1; m_wait = 0;
            if (m_err < 65535) m_err++;
          end
        end
      end
      if (sh) begin m_wait = 1; m_wcnt = 0; end
      prev_v = ddr_write_start_valid; prev_r = ddr_write_start_ready; prev_f = odd_even_flag;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    areset = 1'b1; tick(); tick(); areset = 1'b0;
  endtask

  task automatic pulse_pkt();
    pkt_in_md_en = 1'b1; tick(); pkt_in_md_en = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!ddr_write_start_valid && n < 50) begin tick(); n++; end
    check("start_seen", ddr_write_start_valid, 1);
  endtask

  task automatic do_finish(input bit ok);
    int n = 0;
    while (!ddr_write_finish_ready && n < 50) begin tick(); n++; end
    check("finish_ready_seen", ddr_write_finish_ready, 1);
    ddr_write_finish_valid = 1'b1; ddr_write_finish = ok;
    tick();
    ddr_write_finish_valid = 1'b0; ddr_write_finish = 1'b0;
  endtask

  task automatic run_pkt(input bit ok);
    pulse_pkt(); wait_start(); tick(); do_finish(ok);
  endtask

  initial begin
    reset_dut();
    check("rst_pend", pend_cnt, 0);
    check("rst_valid", ddr_write_start_valid, 0);
    check("rst_flag", odd_even_flag, 0);
    check("rst_err", err_cnt, 0);

    // Start latency and pend accounting
    pkt_in_md_en = 1'b1; tick(); pkt_in_md_en = 1'b0;
    check("t1_pend_after_n", pend_cnt, 1);
    check("t1_valid_n", ddr_write_start_valid, 0);
    tick();
    check("t1_valid_n1", ddr_write_start_valid, 0);
    tick();
    check("t1_valid_n2", ddr_write_start_valid, 1);
    check("t1_start_n2", ddr_write_start, 1);
    check("t1_flag_n2", odd_even_flag, 0);
    tick();
    check("t1_pend_after_hs", pend_cnt, 0);
    do_finish(1'b1);

    // Back-pressure on start
    reset_dut();
    ddr_write_start_ready = 1'b0;
    pulse_pkt(); wait_start();
    repeat (5) begin
      tick();
      check("t2_valid_hold", ddr_write_start_valid, 1);
      check("t2_flag_hold", odd_even_flag, 0);
    end
    check("t2_pend_before", pend_cnt, 1);
    ddr_write_start_ready = 1'b1; tick();
    check("t2_pend_after", pend_cnt, 0);
    check("t2_valid_drop", ddr_write_start_valid, 0);
    do_finish(1'b1);

    // Two frames into both halves
    reset_dut();
    for (int i = 0; i < P; i++) run_pkt(1'b1);
    check("t3_frame_done", frame_done, 1);
    check("t3_buf_id", frame_buf_id, 0);
    check("t3_flag", odd_even_flag, 1);
    tick();
    check("t3_done_pulse", frame_done, 0);
    check("t3_fd_count", fd_count, 1);
    pulse_pkt(); wait_start();
    check("t3_next_flag", odd_even_flag, 1);
    tick(); do_finish(1'b1);
    for (int i = 1; i < P; i++) run_pkt(1'b1);
    check("t4_frame_done", frame_done, 1);
    check("t4_buf_id", frame_buf_id, 1);
    check("t4_flag", odd_even_flag, 0);
    repeat (3) pulse_pkt();
    repeat (8) tick();
    check("t4_stall_pend", pend_cnt, 3);
    check("t4_stall_valid", ddr_write_start_valid, 0);
    check("t4_fd_count", fd_count, 2);
    frame_ack = 1'b1; frame_ack_id = 1'b0; tick(); frame_ack = 1'b0;
    check("t4_ack_a0", ddr_write_start_valid, 0);
    tick();
    check("t4_ack_a1", ddr_write_start_valid, 0);
    tick();
    check("t4_ack_a2", ddr_write_start_valid, 1);
    check("t4_ack_flag", odd_even_flag, 0);
    tick(); do_finish(1'b1);
    repeat (2) begin wait_start(); tick(); do_finish(1'b1); end
    check("t4_pend_drained", pend_cnt, 0);

    // Write error then timeout
    reset_dut();
    run_pkt(1'b0);
    check("t5_err1", err_cnt, 1);
    check("t5_no_done", frame_done, 0);
    pulse_pkt(); wait_start(); tick();
    repeat (T + 2) tick();
    check("t5_timeout", timeout_err, 1);
    check("t5_err2", err_cnt, 2);
    check("t5_idle_ready", ddr_write_finish_ready, 0);
    check("t5_idle_valid", ddr_write_start_valid, 0);

    // Simultaneous inc/dec and saturation
    reset_dut();
    ddr_write_start_ready = 1'b0;
    pulse_pkt(); pulse_pkt(); wait_start();
    check("t6_pend2", pend_cnt, 2);
    pkt_in_md_en = 1'b1; ddr_write_start_ready = 1'b1; tick();
    pkt_in_md_en = 1'b0; ddr_write_start_ready = 1'b0;
    check("t6_pend_same", pend_cnt, 2);
    pkt_in_md_en = 1'b1; repeat (256) tick(); pkt_in_md_en = 1'b0;
    check("t6_pend_sat", pend_cnt, 255);
    check("t6_ovf", pend_ovf, 1);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ddr_buf_ctrl.md
Name: ddr_buf_ctrl

Overview:
- Ping-pong frame-buffer write controller that sits directly upstream of camera_adaptor's DDR write control interface.
- Counts packets that camera_adaptor has accepted and issues one ddr_write_start transaction per packet, with odd_even_flag selecting the DDR buffer half.
- Consumes ddr_write_finish, counts PKTS_PER_FRAME successful writes per frame, then hands the full buffer to the accelerator and flips to the other half.
- Blocks writes into a half the accelerator has not yet released.

Parameters:
- PKTS_PER_FRAME, 16: successful packet writes per frame buffer.
- CNT_W, 8: width of the pending-packet counter.
- TIMEOUT_CYCLES, 4096: maximum cycles in WAIT_FIN before abort.

Ports:
- clk  in  1  system clock.
- areset  in  1  synchronous, active-high reset.
- enable  in  1  permits new write transactions.
- pkt_in_md_en  in  1  one-cycle pulse per packet accepted by the adaptor.
- ddr_write_start  out  1  start command to adaptor; always 1 while ddr_write_start_valid is high.
- ddr_write_start_valid  out  1  start command valid.
- ddr_write_start_ready  in  1  adaptor accepts start.
- odd_even_flag  out  1  current DDR buffer half (0/1).
- ddr_write_finish  in  1  1 = write OK, 0 = write error.
- ddr_write_finish_valid  in  1  finish status valid.
- ddr_write_finish_ready  out  1  controller accepts finish.
- frame_done  out  1  one-cycle pulse when a frame buffer is full.
- frame_buf_id  out  1  buffer half completed; valid with frame_done.
- frame_ack  in  1  accelerator releases a buffer.
- frame_ack_id  in  1  buffer half released by frame_ack.
- pend_cnt  out  CNT_W  packets not yet started.
- err_cnt  out  16  write errors plus timeouts, saturating.
- timeout_err  out  1  sticky timeout flag.
- pend_ovf  out  1  sticky pending-counter overflow flag.

Behaviour:
- Reset (synchronous, clears everything):
  - State = IDLE.
  - All outputs 0, including odd_even_flag = 0 (buffer 0 first).
  - pend_cnt = 0, pkt_cnt = 0, buf_full[1:0] = 0, timer = 0.
  - Reset mid-transaction aborts it with no frame_done.
- pend_cnt:
  - +1 on pkt_in_md_en; -1 on the start handshake (start_valid & start_ready).
  - Increment and decrement in the same cycle: value unchanged.
  - Increment at all-ones: value saturates, pend_ovf set.
- IDLE -> START when enable & pend_cnt != 0 & !buf_full[odd_even_flag], all evaluated on registered values.
  - ddr_write_start and ddr_write_start_valid go high on the next edge.
  - Latency from pkt_in_md_en pulse at edge N to start_valid high: edge N+2.
- START:
  - start_valid, ddr_write_start and odd_even_flag held stable until start_ready.
  - enable is not re-checked here.
  - On handshake: start_valid drops next edge, state -> WAIT_FIN, timer = 0.
- WAIT_FIN:
  - ddr_write_finish_ready = 1 only in this state.
  - On finish handshake with ddr_write_finish = 1: pkt_cnt increments.
  - On finish handshake with ddr_write_finish = 0: err_cnt increments, pkt_cnt unchanged.
  - After either: state -> IDLE.
  - No finish_valid by TIMEOUT_CYCLES cycles: timeout_err set, err_cnt increments, state -> IDLE, pkt_cnt unchanged.
- Frame completion, when pkt_cnt reaches PKTS_PER_FRAME:
  - Same edge: frame_done = 1 for exactly one cycle, frame_buf_id = current odd_even_flag, buf_full[flag] set, flag toggles, pkt_cnt = 0.
  - The next start, if any, uses the new flag.
- Buffer release:
  - frame_ack clears buf_full[frame_ack_id]; ack of a buffer not full is ignored.
  - Set and clear of the same bit in the same cycle: set wins.
  - Both halves full: controller stalls in IDLE with pend_cnt accumulating until an ack.
- enable deasserted mid-transaction: the current transaction completes; no new start issues.
- err_cnt saturates at 16'hFFFF.
- Sticky flags (timeout_err, pend_ovf) clear only on reset.

Test Plan:
1. Reset, enable = 1, start_ready = 1, one pkt_in_md_en pulse at edge N -> pend_cnt = 1 after N; start_valid = 1, ddr_write_start = 1, odd_even_flag = 0 after N+2; pend_cnt = 0 after handshake.
2. Hold start_ready = 0 for 5 cycles -> start_valid, ddr_write_start and odd_even_flag stable throughout; exactly one handshake; pend_cnt decrements once.
3. 16 packets, each finished with finish = 1 -> single frame_done pulse with frame_buf_id = 0; odd_even_flag = 1; next start carries flag 1.
4. 32 packets, no frame_ack, 3 more pulses -> second frame_done with frame_buf_id = 1, flag back to 0, no further start, pend_cnt = 3; frame_ack with frame_ack_id = 0 -> start resumes 2 cycles later.
5. Finish with ddr_write_finish = 0 -> err_cnt = 1, pkt_cnt unchanged, no frame_done; then TIMEOUT_CYCLES with finish_valid = 0 -> timeout_err = 1, err_cnt = 2, state IDLE.
6. pkt_in_md_en and start handshake in the same cycle with pend_cnt = 2 -> pend_cnt stays 2; 256 pulses with start_ready = 0 -> pend_cnt = 255, pend_ovf = 1.
